// File: rtl/lht_ctrl.sv
// Controller for the dual-port 256x4 lht table: saturating read-modify-write updates on
// port 0, pipelined lookups on port 1, zero-fill after reset or on request, write forwarding.
module lht_ctrl #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req_i,
    output logic                  busy_o,
    input  logic                  upd_valid_i,
    output logic                  upd_ready_o,
    input  logic [ADDR_WIDTH-1:0] upd_addr_i,
    input  logic [1:0]            upd_op_i,
    input  logic [DATA_WIDTH-1:0] upd_data_i,
    input  logic                  lkp_valid_i,
    output logic                  lkp_ready_o,
    input  logic [ADDR_WIDTH-1:0] lkp_addr_i,
    output logic                  rsp_valid_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  csb0_o,
    output logic                  web0_o,
    output logic [ADDR_WIDTH-1:0] addr0_o,
    output logic [DATA_WIDTH-1:0] din0_o,
    input  logic [DATA_WIDTH-1:0] dout0_i,
    output logic                  csb1_o,
    output logic                  web1_o,
    output logic [ADDR_WIDTH-1:0] addr1_o,
    output logic [DATA_WIDTH-1:0] din1_o,
    input  logic [DATA_WIDTH-1:0] dout1_i
);

    localparam logic [1:0] CLEAR  = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] RMW_WR = 2'd2;

    localparam logic [DATA_WIDTH-1:0] DATA_MAX  = {DATA_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  busy_q, upd_ready_q, lkp_ready_q;

    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [1:0]            rmw_op_q;
    logic [DATA_WIDTH-1:0] rmw_data_q;
    logic [DATA_WIDTH-1:0] rmw_old, rmw_new;

    logic                  pend_valid_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [DATA_WIDTH-1:0] pend_data_q;

    logic                  lkp_v_q;
    logic [ADDR_WIDTH-1:0] lkp_addr_q;
    logic                  rsp_valid_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic upd_acc, lkp_acc, wr_en, fwd_rmw, fwd_lkp;

    assign upd_acc = upd_valid_i & upd_ready_q;
    assign lkp_acc = lkp_valid_i & lkp_ready_q;
    assign wr_en   = ~csb0_o & ~web0_o;
    assign fwd_rmw = pend_valid_q & (pend_addr_q == rmw_addr_q);
    assign fwd_lkp = pend_valid_q & (pend_addr_q == lkp_addr_q);

    assign busy_o      = busy_q;
    assign upd_ready_o = upd_ready_q;
    assign lkp_ready_o = lkp_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_data_o  = rsp_data_q;

    assign csb1_o  = ~lkp_acc;
    assign web1_o  = 1'b1;
    assign addr1_o = lkp_addr_i;
    assign din1_o  = '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, port 0 drive and saturating update arithmetic
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_pend_d = clr_pend_q;
        csb0_o     = 1'b1;
        web0_o     = 1'b1;
        addr0_o    = '0;
        din0_o     = '0;
        rmw_old    = fwd_rmw ? pend_data_q : dout0_i;
        rmw_new    = '0;

        case (rmw_op_q)
            2'b00:   rmw_new = (rmw_old == DATA_MAX) ? DATA_MAX : rmw_old + DATA_WIDTH'(1);
            2'b01:   rmw_new = (rmw_old == '0) ? '0 : rmw_old - DATA_WIDTH'(1);
            2'b10:   rmw_new = rmw_data_q;
            default: rmw_new = '0;
        endcase

        case (state_q)
            CLEAR: begin
                clr_pend_d = 1'b0;
                // Port 0 stays quiet while reset is held; the fill begins once it lifts
                csb0_o     = ~rst_n;
                web0_o     = ~rst_n;
                addr0_o    = clr_ptr_q;
                clr_ptr_d  = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == ADDR_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (upd_acc) begin
                    csb0_o     = 1'b0;
                    addr0_o    = upd_addr_i;
                    state_d    = RMW_WR;
                    clr_pend_d = clr_req_i;
                end else if (clr_req_i) begin
                    state_d = CLEAR;
                end
            end
            RMW_WR: begin
                csb0_o     = 1'b0;
                web0_o     = 1'b0;
                addr0_o    = rmw_addr_q;
                din0_o     = rmw_new;
                clr_pend_d = 1'b0;
                state_d    = (clr_req_i | clr_pend_q) ? CLEAR : IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Control registers: fill pointer, deferred clear, readies and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr_q   <= '0;
            clr_pend_q  <= 1'b0;
            busy_q      <= 1'b1;
            upd_ready_q <= 1'b0;
            lkp_ready_q <= 1'b0;
        end else begin
            clr_ptr_q   <= clr_ptr_d;
            clr_pend_q  <= clr_pend_d;
            busy_q      <= (state_d == CLEAR) | clr_pend_d;
            upd_ready_q <= (state_d == IDLE);
            lkp_ready_q <= (state_d != CLEAR);
        end
    end

    // Latched update request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmw_addr_q <= '0;
            rmw_op_q   <= 2'b00;
            rmw_data_q <= '0;
        end else if (upd_acc) begin
            rmw_addr_q <= upd_addr_i;
            rmw_op_q   <= upd_op_i;
            rmw_data_q <= upd_data_i;
        end
    end

    // Last write issued; once committed it matches the array, so holding it is harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else if (wr_en) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= addr0_o;
            pend_data_q  <= din0_o;
        end
    end

    // Lookup pipeline: address tracked alongside the SRAM read, forwarded on response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkp_v_q     <= 1'b0;
            lkp_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            lkp_v_q     <= lkp_acc;
            rsp_valid_q <= lkp_v_q;
            if (lkp_acc) begin
                lkp_addr_q <= lkp_addr_i;
            end
            if (lkp_v_q) begin
                rsp_addr_q <= lkp_addr_q;
                rsp_data_q <= fwd_lkp ? pend_data_q : dout1_i;
            end
        end
    end

endmodule

// File: tb/tb_lht_ctrl.sv
// Scoreboard bench for lht_ctrl with a registered-address dual-port SRAM model
// whose writes land one edge after they are sampled.
module tb_lht_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       busy;
    logic       upd_valid, upd_ready;
    logic [7:0] upd_addr;
    logic [1:0] upd_op;
    logic [3:0] upd_data;
    logic       lkp_valid, lkp_ready;
    logic [7:0] lkp_addr;
    logic       rsp_valid;
    logic [7:0] rsp_addr;
    logic [3:0] rsp_data;
    logic       csb0, web0, csb1, web1;
    logic [7:0] addr0, addr1;
    logic [3:0] din0, din1, dout0, dout1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0] ref_mem [256];

    lht_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr_req_i(clr_req), .busy_o(busy),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_addr_i(upd_addr),
        .upd_op_i(upd_op), .upd_data_i(upd_data),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
        .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data),
        .csb0_o(csb0), .web0_o(web0), .addr0_o(addr0), .din0_o(din0), .dout0_i(dout0),
        .csb1_o(csb1), .web1_o(web1), .addr1_o(addr1), .din1_o(din1), .dout1_i(dout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: inputs registered at the edge, write committed at the following edge
    logic [3:0] mem [256];
    logic       cs0_q = 1'b1, we0_q = 1'b1;
    logic [7:0] a0_q = 8'h00, a1_q = 8'h00;
    logic [3:0] d0_q = 4'h0;

    always @(posedge clk) begin
        if (!cs0_q && !we0_q) mem[a0_q] <= d0_q;
        cs0_q <= csb0;
        we0_q <= web0;
        if (!csb0) begin
            a0_q <= addr0;
            d0_q <= din0;
        end
        if (!csb1) a1_q <= addr1;
    end
    assign dout0 = mem[a0_q];
    assign dout1 = mem[a1_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_rmw(input logic [3:0] old, input logic [1:0] op,
                                             input logic [3:0] d);
        case (op)
            2'b00:   return (old == 4'd15) ? 4'd15 : old + 4'd1;
            2'b01:   return (old == 4'd0) ? 4'd0 : old - 4'd1;
            2'b10:   return d;
            default: return 4'd0;
        endcase
    endfunction

    // Called and returns at a negedge; acceptance is decided from the readies visible now
    task automatic drive_cycle(input logic uv, input logic [7:0] ua, input logic [1:0] uop,
                               input logic [3:0] ud, input logic lv, input logic [7:0] la,
                               input logic clr, output logic uacc);
        exp_t e;
        upd_valid = uv; upd_addr = ua; upd_op = uop; upd_data = ud;
        lkp_valid = lv; lkp_addr = la; clr_req = clr;
        uacc = uv && upd_ready;
        if (lv && lkp_ready) begin
            e.addr = la; e.data = ref_mem[la]; e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        if (uacc) ref_mem[ua] = model_rmw(ref_mem[ua], uop, ud);
        if (clr) for (int i = 0; i < 256; i++) ref_mem[i] = 4'd0;
        @(posedge clk);
        #1;
        upd_valid = 1'b0; lkp_valid = 1'b0; clr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_upd(input logic [7:0] ua, input logic [1:0] uop, input logic [3:0] ud);
        logic acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) drive_cycle(1'b1, ua, uop, ud, 1'b0, 8'h00, 1'b0, acc);
        check("upd_accept", 32'(acc), 32'd1);
    endtask

    task automatic lookup(input logic [7:0] la);
        logic acc;
        check("lkp_ready", 32'(lkp_ready), 32'd1);
        drive_cycle(1'b0, 8'h00, 2'b00, 4'h0, 1'b1, la, 1'b0, acc);
    endtask

    task automatic idle_cycle();
        logic acc;
        drive_cycle(1'b0, 8'h00, 2'b00, 4'h0, 1'b0, 8'h00, 1'b0, acc);
    endtask

    // Counts edges until lkp_ready is seen; checks busy just before and at the handover
    task automatic wait_clear(input string tag);
        int n = 0;
        while (!lkp_ready && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 255) begin
                check({tag, "_busy255"}, 32'(busy), 32'd1);
                check({tag, "_rdy255"}, 32'(lkp_ready), 32'd0);
            end
        end
        check({tag, "_cycles"}, 32'(n), 32'd256);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_upd_rdy"}, 32'(upd_ready), 32'd1);
    endtask

    // Response checker
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic acc;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 4'($urandom_range(0, 15));
            ref_mem[i] = 4'd0;
        end
        rst_n = 1'b0; clr_req = 1'b0;
        upd_valid = 1'b0; upd_addr = 8'h00; upd_op = 2'b00; upd_data = 4'h0;
        lkp_valid = 1'b0; lkp_addr = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd1);
        check("rst_upd_ready", 32'(upd_ready), 32'd0);
        check("rst_lkp_ready", 32'(lkp_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_csb1", 32'(csb1), 32'd1);
        check("rst_web0", 32'(web0), 32'd1);

        // Release reset with a lookup already waiting
        lkp_valid = 1'b1; lkp_addr = 8'hFF;
        rst_n = 1'b1;
        #1;
        check("fill_first_csb0", 32'(csb0), 32'd0);
        check("fill_first_addr0", 32'(addr0), 32'd0);
        wait_clear("init");
        lookup(8'hFF);

        // Saturation at both ends
        for (int i = 0; i < 17; i++) do_upd(8'h10, 2'b00, 4'h0);
        idle_cycle();
        lookup(8'h10);
        for (int i = 0; i < 2; i++) do_upd(8'h11, 2'b01, 4'h0);
        idle_cycle();
        lookup(8'h11);

        // Back-to-back write then increment, lookup right behind the increment
        do_upd(8'h20, 2'b10, 4'd5);
        do_upd(8'h20, 2'b00, 4'h0);
        lookup(8'h20);

        // Update and lookup to the same address at the same edge
        do_upd(8'h30, 2'b10, 4'd3);
        idle_cycle();
        drive_cycle(1'b1, 8'h30, 2'b00, 4'h0, 1'b1, 8'h30, 1'b0, acc);
        check("simul_upd_acc", 32'(acc), 32'd1);
        lookup(8'h30);

        // Lookup streaming with interleaved updates that hit the lookup addresses
        for (int i = 0; i < 256; i++) begin
            drive_cycle((i % 3) == 0, (i % 2) ? 8'(i + 1) : 8'(i),
                        2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                        1'b1, 8'(i), 1'b0, acc);
        end
        repeat (3) idle_cycle();

        // Clear requested while the RMW write is being issued
        do_upd(8'h40, 2'b10, 4'd7);
        idle_cycle();
        do_upd(8'h40, 2'b00, 4'h0);
        check("rmw_wr_csb0", 32'(csb0), 32'd0);
        check("rmw_wr_web0", 32'(web0), 32'd0);
        check("rmw_wr_addr0", 32'(addr0), 32'h40);
        check("rmw_wr_din0", 32'(din0), 32'd8);
        drive_cycle(1'b0, 8'h00, 2'b00, 4'h0, 1'b1, 8'h40, 1'b1, acc);
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_lkp_ready", 32'(lkp_ready), 32'd0);
        wait_clear("rmwclr");
        lookup(8'h40);
        lookup(8'h10);

        repeat (5) idle_cycle();
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
